// File: rtl/shift_pkg.sv
// Shared definitions for the shift decode/issue stage.
//   - shifter control (aluc) encodings
//   - MIPS R-type opcode and shift funct codes
//   - shift_op_t: the operand bundle handed to the barrel shifter
package shift_pkg;

    // Shifter control: bit 1 = logical, bit 0 = left
    localparam logic [1:0] ALUC_SRA = 2'b00;
    localparam logic [1:0] ALUC_SLA = 2'b01;
    localparam logic [1:0] ALUC_SRL = 2'b10;
    localparam logic [1:0] ALUC_SLL = 2'b11;

    localparam logic [5:0] OPC_RTYPE  = 6'b000000;

    localparam logic [5:0] FUNCT_SLL  = 6'b000000;
    localparam logic [5:0] FUNCT_SRL  = 6'b000010;
    localparam logic [5:0] FUNCT_SRA  = 6'b000011;
    localparam logic [5:0] FUNCT_SLLV = 6'b000100;
    localparam logic [5:0] FUNCT_SRLV = 6'b000110;
    localparam logic [5:0] FUNCT_SRAV = 6'b000111;

    typedef struct packed {
        logic [31:0] a;
        logic [4:0]  b;
        logic [1:0]  aluc;
        logic [4:0]  rd;
    } shift_op_t;

    // Value the output register takes on reset
    localparam shift_op_t OP_RESET = '{a: 32'h0, b: 5'h0, aluc: ALUC_SLL, rd: 5'h0};

endpackage

// File: rtl/shift_decode.sv
// Combinational decoder for R-type shift instructions.
// Ports:
//   instr  [31:0] in  : MIPS instruction word
//   rs_val [31:0] in  : value of register rs (only [4:0] used, as variable shift amount)
//   rt_val [31:0] in  : value of register rt (data to shift)
//   op            out : decoded shifter operands (a, b, aluc, rd)
//   legal         out : instruction is one of sll/srl/sra/sllv/srlv/srav
module shift_decode
    import shift_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output shift_op_t   op,
    output logic        legal
);

    // rs/rt register fields and upper rs_val bits are not needed here
    logic unused_bits;
    assign unused_bits = ^{rs_val[31:5], instr[25:16]};

    always_comb begin
        op.a    = rt_val;
        op.rd   = instr[15:11];
        op.b    = instr[10:6];
        op.aluc = ALUC_SLL;
        legal   = 1'b0;
        if (instr[31:26] == OPC_RTYPE) begin
            case (instr[5:0])
                FUNCT_SLL: begin
                    legal   = 1'b1;
                    op.aluc = ALUC_SLL;
                end
                FUNCT_SRL: begin
                    legal   = 1'b1;
                    op.aluc = ALUC_SRL;
                end
                FUNCT_SRA: begin
                    legal   = 1'b1;
                    op.aluc = ALUC_SRA;
                end
                FUNCT_SLLV: begin
                    legal   = 1'b1;
                    op.aluc = ALUC_SLL;
                    op.b    = rs_val[4:0];
                end
                FUNCT_SRLV: begin
                    legal   = 1'b1;
                    op.aluc = ALUC_SRL;
                    op.b    = rs_val[4:0];
                end
                FUNCT_SRAV: begin
                    legal   = 1'b1;
                    op.aluc = ALUC_SRA;
                    op.b    = rs_val[4:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/shift_decode_stage.sv
// Decode/issue stage in front of the 32-bit barrel shifter.
// Legal shift instructions are decoded into shifter operands and passed through a
// 2-entry skid buffer (main + skid); illegal instructions are consumed and counted.
// Ports:
//   clk, rst_n              : clock, async active-low reset
//   flush                   : synchronous kill of all buffered entries
//   in_valid / in_ready     : upstream handshake (in_ready is a flop output)
//   instr, rs_val, rt_val   : instruction and register operands
//   out_valid / out_ready   : downstream handshake
//   out_a, out_b, out_aluc, out_rd : shifter operands from the main register
//   illegal_pulse           : one-cycle pulse after an illegal instruction is consumed
//   illegal_cnt             : saturating illegal-instruction count
module shift_decode_stage
    import shift_pkg::*;
#(
    parameter int unsigned ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instr,
    input  logic [31:0]          rs_val,
    input  logic [31:0]          rt_val,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_a,
    output logic [4:0]           out_b,
    output logic [1:0]           out_aluc,
    output logic [4:0]           out_rd,
    output logic                 illegal_pulse,
    output logic [ILL_CNT_W-1:0] illegal_cnt
);

    shift_op_t dec_op;
    logic      dec_legal;

    shift_decode u_decode (
        .instr  (instr),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .op     (dec_op),
        .legal  (dec_legal)
    );

    logic                 main_valid_q, main_valid_d;
    shift_op_t            main_op_q, main_op_d;
    logic                 skid_valid_q, skid_valid_d;
    shift_op_t            skid_op_q, skid_op_d;
    logic                 ill_pulse_q;
    logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;

    logic accept, acc_legal, acc_illegal, emit;

    // in_ready comes straight from the skid flop: no path from out_ready
    assign in_ready    = ~skid_valid_q;
    assign accept      = in_valid & in_ready;
    assign acc_legal   = accept & dec_legal;
    assign acc_illegal = accept & ~dec_legal;
    assign emit        = main_valid_q & out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_op_d    = main_op_q;
        skid_valid_d = skid_valid_q;
        skid_op_d    = skid_op_q;
        if (flush) begin
            // Data is left in place; only the valids are killed
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || emit) begin
            // Main is free this edge: refill from skid first to keep FIFO order.
            // A full skid implies in_ready=0, so no accept competes with it.
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_op_d    = skid_op_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = acc_legal;
                if (acc_legal) begin
                    main_op_d = dec_op;
                end
            end
        end else if (acc_legal) begin
            // Main is stalled; skid is known empty because we accepted
            skid_valid_d = 1'b1;
            skid_op_d    = dec_op;
        end
    end

    always_comb begin
        ill_cnt_d = ill_cnt_q;
        if (acc_illegal && (ill_cnt_q != {ILL_CNT_W{1'b1}})) begin
            ill_cnt_d = ill_cnt_q + ILL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_op_q    <= OP_RESET;
            skid_valid_q <= 1'b0;
            skid_op_q    <= OP_RESET;
            ill_pulse_q  <= 1'b0;
            ill_cnt_q    <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_op_q    <= main_op_d;
            skid_valid_q <= skid_valid_d;
            skid_op_q    <= skid_op_d;
            ill_pulse_q  <= acc_illegal;
            ill_cnt_q    <= ill_cnt_d;
        end
    end

    assign out_valid     = main_valid_q;
    assign out_a         = main_op_q.a;
    assign out_b         = main_op_q.b;
    assign out_aluc      = main_op_q.aluc;
    assign out_rd        = main_op_q.rd;
    assign illegal_pulse = ill_pulse_q;
    assign illegal_cnt   = ill_cnt_q;

endmodule

// File: tb/tb_shift_decode_stage.sv
module tb_shift_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [4:0]  out_b;
    logic [1:0]  out_aluc;
    logic [4:0]  out_rd;
    logic        illegal_pulse;
    logic [7:0]  illegal_cnt;

    shift_decode_stage #(.ILL_CNT_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .instr         (instr),
        .rs_val        (rs_val),
        .rt_val        (rt_val),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_a         (out_a),
        .out_b         (out_b),
        .out_aluc      (out_aluc),
        .out_rd        (out_rd),
        .illegal_pulse (illegal_pulse),
        .illegal_cnt   (illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [4:0]  b;
        logic [1:0]  aluc;
        logic [4:0]  rd;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_cnt = 0;
    bit   exp_pulse = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: instruction table -> expected shifter operands
    function automatic bit ref_decode(input logic [31:0] i, input logic [31:0] rs,
                                      input logic [31:0] rt, output exp_t e);
        e.a  = rt;
        e.rd = i[15:11];
        e.b  = 5'd0;
        e.aluc = 2'b11;
        if (i[31:26] != 6'd0) return 1'b0;
        case (i[5:0])
            6'd0: begin e.aluc = 2'b11; e.b = i[10:6];   end
            6'd2: begin e.aluc = 2'b10; e.b = i[10:6];   end
            6'd3: begin e.aluc = 2'b00; e.b = i[10:6];   end
            6'd4: begin e.aluc = 2'b11; e.b = rs % 32;   end
            6'd6: begin e.aluc = 2'b10; e.b = rs % 32;   end
            6'd7: begin e.aluc = 2'b00; e.b = rs % 32;   end
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    function automatic logic [31:0] mk_r(input logic [5:0] funct, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] shamt);
        return {6'd0, rs, rt, rd, shamt, funct};
    endfunction

    // Stimulus side: record what the DUT accepted, after the monitor has run
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (!rst_n) begin
            q.delete();
            exp_pulse = 0;
            exp_cnt   = 0;
        end else begin
            exp_pulse = 0;
            if (in_valid && in_ready) begin
                if (ref_decode(instr, rs_val, rt_val, e)) begin
                    if (!flush) q.push_back(e);
                end else begin
                    exp_pulse = 1;
                    if (exp_cnt != 255) exp_cnt++;
                end
            end
            if (flush) q.delete();
        end
    end

    // Monitor: compare DUT state and any emitted entry against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            chk("in_ready", in_ready, (q.size() < 2) ? 1 : 0);
            chk("out_valid", out_valid, (q.size() != 0) ? 1 : 0);
            chk("illegal_pulse", illegal_pulse, exp_pulse);
            chk("illegal_cnt", illegal_cnt, exp_cnt);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_emit: got a=%h b=%h expected nothing", out_a, out_b);
                end else begin
                    e = q.pop_front();
                    chk("out_a", out_a, e.a);
                    chk("out_b", out_b, e.b);
                    chk("out_aluc", out_aluc, e.aluc);
                    chk("out_rd", out_rd, e.rd);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
        bit acc;
        instr    = i;
        rs_val   = rs;
        rt_val   = rt;
        in_valid = 1'b1;
        acc      = 1'b0;
        for (int k = 0; k < 100 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: got in_ready=0 for 100 cycles expected acceptance");
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [5:0] functs [6];
    logic [31:0] r;

    initial begin
        functs = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7};
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        instr     = 32'h0;
        rs_val    = 32'h0;
        rt_val    = 32'h0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset values
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_a", out_a, 0);
        chk("rst_out_b", out_b, 0);
        chk("rst_out_aluc", out_aluc, 2'b11);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_illegal_pulse", illegal_pulse, 0);
        chk("rst_illegal_cnt", illegal_cnt, 0);
        @(posedge clk);
        #1;

        // sra $t1, $t0, 4 ; srlv ; sllv ; nop
        send(mk_r(6'd3, 5'd0, 5'd8, 5'd9, 5'd4), 32'h1234_5678, 32'h8000_0000);
        @(negedge clk);
        chk("sra_out_b", out_b, 4);
        chk("sra_out_aluc", out_aluc, 2'b00);
        chk("sra_out_a", out_a, 32'h8000_0000);
        @(posedge clk);
        #1;
        send(mk_r(6'd6, 5'd3, 5'd4, 5'd5, 5'd17), 32'hFFFF_FFE3, 32'hCAFE_F00D);
        send(mk_r(6'd4, 5'd3, 5'd4, 5'd6, 5'd0), 32'h0000_001F, 32'h0000_0001);
        send(32'h0, 32'h5, 32'h7);
        idle(3);

        // Stall: three back-to-back with downstream blocked
        out_ready = 1'b0;
        fork
            begin
                send(mk_r(6'd0, 5'd1, 5'd2, 5'd10, 5'd1), 32'h0, 32'h11);
                send(mk_r(6'd2, 5'd1, 5'd2, 5'd11, 5'd2), 32'h0, 32'h22);
                send(mk_r(6'd7, 5'd1, 5'd2, 5'd12, 5'd3), 32'h9, 32'h33);
            end
            begin
                idle(6);
                out_ready = 1'b1;
            end
        join
        idle(4);

        // Illegal instruction, then saturation
        send({6'b001000, 26'h0123456}, 32'h0, 32'h0);
        idle(3);
        chk("illegal_cnt_one", illegal_cnt, 1);
        instr    = {6'b001000, 26'h0000001};
        in_valid = 1'b1;
        idle(300);
        in_valid = 1'b0;
        idle(2);
        chk("illegal_cnt_sat", illegal_cnt, 255);

        // Flush with both entries full
        out_ready = 1'b0;
        send(mk_r(6'd0, 5'd0, 5'd1, 5'd2, 5'd3), 32'h0, 32'hAAAA_0001);
        send(mk_r(6'd2, 5'd0, 5'd1, 5'd2, 5'd4), 32'h0, 32'hAAAA_0002);
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        // Flush while a legal accept happens in the same cycle
        send(mk_r(6'd3, 5'd0, 5'd1, 5'd2, 5'd5), 32'h0, 32'hBBBB_0001);
        flush    = 1'b1;
        in_valid = 1'b1;
        instr    = mk_r(6'd0, 5'd0, 5'd1, 5'd7, 5'd6);
        rt_val   = 32'hDEAD_BEEF;
        idle(1);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(4);

        // Asynchronous reset while out_valid is high
        out_ready = 1'b0;
        send(mk_r(6'd2, 5'd0, 5'd1, 5'd3, 5'd8), 32'h0, 32'hCCCC_0001);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        idle(2);

        // Randomised traffic
        for (int n = 0; n < 2000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            rs_val    = $urandom();
            rt_val    = $urandom();
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5, 6: begin
                    r     = $urandom();
                    instr = mk_r(functs[$urandom_range(0, 5)], r[4:0], r[9:5], r[14:10],
                                 r[19:15]);
                end
                7:       instr = 32'h0;
                default: instr = $urandom();
            endcase
            idle(1);
        end

        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        idle(10);
        chk("drain_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
